instr_issue: RTL and testbench

//  Upstream stage of the CPU controller: buffers incoming 16-bit instructions in a small FIFO,

---
 rtl/instr_issue.sv | 132 +++++++++++++
 tb/tb_instr_issue.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_issue.sv
// rtl/instr_issue.sv - instruction FIFO, IR latch/decode and start/waiting launch handshake
// Optional ILLEGAL_TRAP_EN: drop unsupported {opcode,ALU_op} words at the FIFO head and pulse illegal.
module instr_issue #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [15:0]      in_instr,
   output logic             in_ready,
   input  logic             waiting,
   output logic             start,
   output logic [2:0]       opcode,
   output logic [1:0]       ALU_op,
   output logic [2:0]       rn,
   output logic [2:0]       rd,
   output logic [1:0]       shift_op,
   output logic [2:0]       rm,
   output logic [15:0]      sximm8,
   output logic [15:0]      sximm5,
   output logic [CNT_W-1:0] issued,
   output logic             illegal
);
   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {IDLE, ISSUE, ACK, BUSY} state_t;

   state_t           state, state_n;
   logic [15:0]      mem [DEPTH];
   logic [AW:0]      wr_ptr, rd_ptr;
   logic [15:0]      head;
   logic [15:0]      ir;
   logic             empty, full, push, pop, load, drop;
   logic             first_launch;

   // Extra pointer bit distinguishes full from empty when the index bits match.
   assign empty    = (wr_ptr == rd_ptr);
   assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign head     = mem[rd_ptr[AW-1:0]];
   assign in_ready = !full && !rst;
   assign push     = in_valid && in_ready;

`ifdef ILLEGAL_TRAP_EN
   logic head_legal;
   assign head_legal = (head[15:11] == 5'b11010) || (head[15:11] == 5'b11000) ||
                       (head[15:13] == 3'b101);
`endif

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr[AW-1:0]] <= in_instr;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_comb begin
      state_n = state;
      pop     = 1'b0;
      load    = 1'b0;
      drop    = 1'b0;
      case (state)
         IDLE: begin
            if (!empty) begin
`ifdef ILLEGAL_TRAP_EN
               if (!head_legal) begin
                  pop  = 1'b1;
                  drop = 1'b1;
               end else if (waiting) begin
                  pop     = 1'b1;
                  load    = 1'b1;
                  state_n = ISSUE;
               end
`else
               if (waiting) begin
                  pop     = 1'b1;
                  load    = 1'b1;
                  state_n = ISSUE;
               end
`endif
            end
         end
         ISSUE:   state_n = ACK;
         ACK:     state_n = waiting ? ISSUE : BUSY;
         BUSY:    if (waiting) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   assign start   = (state == ISSUE) && !rst;
   assign illegal = drop && !rst;

   // first_launch keeps re-issues from ACK out of the issued count.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         ir           <= '0;
         issued       <= '0;
         first_launch <= 1'b0;
      end else begin
         state <= state_n;
         if (load) begin
            ir           <= head;
            first_launch <= 1'b1;
         end
         if (state == ISSUE) begin
            first_launch <= 1'b0;
            if (first_launch)
               issued <= issued + 1'b1;
         end
      end
   end

   assign opcode   = ir[15:13];
   assign ALU_op   = ir[12:11];
   assign rn       = ir[10:8];
   assign rd       = ir[7:5];
   assign shift_op = ir[4:3];
   assign rm       = ir[2:0];
   assign sximm8   = {{8{ir[7]}}, ir[7:0]};
   assign sximm5   = {{11{ir[4]}}, ir[4:0]};
endmodule

// File: tb/tb_instr_issue.sv
// tb/tb_instr_issue.sv - self-checking bench for instr_issue against a queue-based launch model
// Honours ILLEGAL_TRAP_EN the same way as the design build.
module tb_instr_issue;
   localparam int DEPTH = 4;
   localparam int CNT_W = 8;
`ifdef ILLEGAL_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             in_valid = 1'b0;
   logic [15:0]      in_instr = '0;
   logic             in_ready;
   logic             waiting = 1'b0;
   logic             start;
   logic [2:0]       opcode, rn, rd, rm;
   logic [1:0]       ALU_op, shift_op;
   logic [15:0]      sximm8, sximm5;
   logic [CNT_W-1:0] issued;
   logic             illegal;

   int errors = 0;
   int checks = 0;
   int exp_issued = 0;
   logic [15:0] model_q[$];

   instr_issue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_instr(in_instr), .in_ready(in_ready),
      .waiting(waiting), .start(start), .opcode(opcode), .ALU_op(ALU_op), .rn(rn), .rd(rd),
      .shift_op(shift_op), .rm(rm), .sximm8(sximm8), .sximm5(sximm5), .issued(issued),
      .illegal(illegal)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic bit legal(input logic [15:0] w);
      int op5 = int'(w) / 2048;
      return (op5 == 26) || (op5 == 24) || (op5 / 4 == 5);
   endfunction

   task automatic check_fields(input string tag, input logic [15:0] w);
      int v  = int'(w);
      int s8 = v % 256;
      int s5 = v % 32;
      if (s8 >= 128) s8 -= 256;
      if (s5 >= 16)  s5 -= 32;
      chk({tag, "_opcode"}, 32'(opcode),   32'(v / 8192));
      chk({tag, "_alu"},    32'(ALU_op),   32'((v / 2048) % 4));
      chk({tag, "_rn"},     32'(rn),       32'((v / 256) % 8));
      chk({tag, "_rd"},     32'(rd),       32'((v / 32) % 8));
      chk({tag, "_shift"},  32'(shift_op), 32'((v / 8) % 4));
      chk({tag, "_rm"},     32'(rm),       32'(v % 8));
      chk({tag, "_sx8"},    32'(sximm8),   32'(s8) & 32'hFFFF);
      chk({tag, "_sx5"},    32'(sximm5),   32'(s5) & 32'hFFFF);
   endtask

   task automatic push_word(input logic [15:0] w);
      in_valid = 1'b1;
      in_instr = w;
      if (in_ready && (legal(w) || !TRAP))
         model_q.push_back(w);
      tick();
      in_valid = 1'b0;
   endtask

   task automatic wait_start(input string tag);
      int n = 0;
      while (start !== 1'b1 && n < 40) begin
         tick();
         n++;
      end
      chk(tag, 32'(start), 32'd1);
   endtask

   // Controller model: accept one launch, drop waiting in the following cycle, stay busy, return.
   task automatic expect_launch(input string tag, input int busy);
      logic [15:0] w;
      wait_start({tag, "_start"});
      if (model_q.size() == 0) begin
         chk({tag, "_model_has_word"}, 32'd0, 32'd1);
         return;
      end
      w = model_q.pop_front();
      check_fields(tag, w);
      chk({tag, "_issued_pre"}, 32'(issued), 32'(exp_issued % 256));
      exp_issued++;
      tick();
      chk({tag, "_ack_start"}, 32'(start), 32'd0);
      chk({tag, "_issued"}, 32'(issued), 32'(exp_issued % 256));
      waiting = 1'b0;
      tick();
      for (int i = 0; i < busy; i++) begin
         chk({tag, "_busy_start"}, 32'(start), 32'd0);
         check_fields({tag, "_busy"}, w);
         tick();
      end
      waiting = 1'b1;
      tick();
   endtask

   initial begin
      logic [4:0] ops [7] = '{5'd26, 5'd24, 5'd20, 5'd22, 5'd23, 5'd28, 5'd0};
      int legal_n;

      // Reset state
      tick();
      tick();
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_start", 32'(start), 32'd0);
      chk("rst_issued", 32'(issued), 32'd0);
      chk("rst_illegal", 32'(illegal), 32'd0);
      check_fields("rst", 16'h0000);
      rst = 1'b0;
      tick();
      chk("post_rst_in_ready", 32'(in_ready), 32'd1);

      // Test 1: latency and decode of D207
      waiting = 1'b1;
      push_word(16'hD207);
      chk("t1_lat_t1", 32'(start), 32'd0);
      tick();
      chk("t1_lat_t2", 32'(start), 32'd1);
      expect_launch("t1", 1);

      // Test 2: fields stable while busy; queued second word waits for waiting to return
      push_word(16'hA141);
      push_word(16'hB000);
      expect_launch("t2a", 4);
      expect_launch("t2b", 1);

      // Test 3: negative immediates
      push_word(16'hD3FF);
      expect_launch("t3", 1);

      // Test 4: fill FIFO while controller busy, then drain in order
      waiting = 1'b0;
      for (int i = 0; i <= DEPTH; i++) begin
         chk("t4_ready", 32'(in_ready), (i < DEPTH) ? 32'd1 : 32'd0);
         push_word(16'hA000 | 16'(i * 16'h0123));
      end
      waiting = 1'b1;
      for (int i = 0; i < DEPTH; i++)
         expect_launch("t4", 1);

      // Test 5: stuck waiting re-pulses start without recounting; reset mid-BUSY
      push_word(16'hA5A5);
      wait_start("t5_start");
      void'(model_q.pop_front());
      exp_issued++;
      for (int i = 1; i <= 4; i++) begin
         tick();
         chk("t5_repulse", 32'(start), (i % 2 == 0) ? 32'd1 : 32'd0);
         chk("t5_issued", 32'(issued), 32'(exp_issued % 256));
      end
      waiting = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      tick();
      chk("t5_rst_start", 32'(start), 32'd0);
      chk("t5_rst_issued", 32'(issued), 32'd0);
      chk("t5_rst_in_ready", 32'(in_ready), 32'd0);
      check_fields("t5_rst", 16'h0000);
      rst = 1'b0;
      exp_issued = 0;
      model_q.delete();
      tick();
      chk("t5_in_ready", 32'(in_ready), 32'd1);

      // Test 6: illegal word handling
      waiting = 1'b1;
      push_word(16'hE000);
      chk("t6_illegal", 32'(illegal), TRAP ? 32'd1 : 32'd0);
      chk("t6_no_start", 32'(start), 32'd0);
      push_word(16'hD207);
      for (int i = 0; i < (TRAP ? 1 : 2); i++)
         expect_launch("t6", 1);
      chk("t6_issued", 32'(issued), TRAP ? 32'd1 : 32'd2);

      // Randomized bursts against the model
      for (int it = 0; it < 20; it++) begin
         int k = int'($urandom_range(1, DEPTH));
         waiting = 1'b0;
         repeat (DEPTH + 1) tick();
         legal_n = model_q.size();
         for (int j = 0; j < k; j++) begin
            logic [15:0] w;
            w = {ops[$urandom_range(0, 6)], 11'($urandom)};
            chk("rand_ready", 32'(in_ready), 32'd1);
            push_word(w);
         end
         legal_n = model_q.size() - legal_n;
         waiting = 1'b1;
         for (int j = 0; j < legal_n; j++)
            expect_launch("rand", int'($urandom_range(0, 3)));
      end
      chk("rand_model_drained", 32'(model_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
